fp_alu_dispatch: RTL
====================

Name: fp_alu_dispatch

Overview:
Dual-format floating-point ALU front end with a valid/ready request interface, per-request format select, tagging, a response FIFO and a watchdog.
It wraps two existing fp_alu_core instances: a wide one (E_HI/F_HI) and a narrow one (E_LO/F_LO).
It serialises requests to the selected core and returns results with their tags on a valid/ready response port.
It replaces direct start/valid_out wiring at the top level, so upstream logic can stream operations without tracking core latency.

Parameters:
E_HI, 8, exponent width of the wide core
F_HI, 23, fraction width of the wide core (E_HI+F_HI+1 must be 32)
E_LO, 5, exponent width of the narrow core
F_LO, 10, fraction width of the narrow core (E_LO+F_LO+1 must be 16)
FIFO_DEPTH, 4, response FIFO entries (power of two, >=2)
TAG_W, 4, request tag width
TIMEOUT, 64, max cycles to wait for core valid_out before forced completion

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV; others illegal
in_mode  in  1  0=half (16 LSBs used), 1=single
in_a, in_b  in  32  operands
in_tag  in  TAG_W  opaque request tag
out_valid  out  1  response valid
out_ready  in  1  response consumed when out_valid&out_ready
out_result  out  32  result; half mode zero-extended in [31:16]
out_flags  out  5  core flags; flags[4]=invalid
out_tag  out  TAG_W  tag of the request
out_mode  out  1  mode of the request
out_timeout  out  1  entry was forced by the watchdog
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; FIFO empty; in_ready=0 during reset, then 1 from the first cycle after release; out_valid=0; out_result/flags/tag/mode/timeout=0; busy=0; fifo_count=0; watchdog=0.
- FSM states: IDLE, ISSUE, WAIT, PUSH.
  - IDLE: in_ready = (fifo_count < FIFO_DEPTH). On accept, latch op/mode/a/b/tag. Legal op -> ISSUE. Illegal op -> PUSH with result 0, flags 5'b10000, no core start.
  - ISSUE: one-cycle start pulse to the core selected by the latched mode only. Half core gets a[15:0]/b[15:0]. Watchdog cleared. -> WAIT.
  - WAIT: watchdog increments each cycle. Selected core valid_out -> capture result/flags -> PUSH. Watchdog reaches TIMEOUT-1 without valid_out -> PUSH with result 0, flags 5'b10000, timeout=1.
  - PUSH: write entry {result, flags, tag, mode, timeout} into FIFO -> IDLE.
- Only one operation is outstanding; in_ready=0 in ISSUE/WAIT/PUSH.
- valid_out from the non-selected core is ignored. A late valid_out after a timeout is ignored.
- FIFO space is checked at accept, so PUSH never overflows.
- FIFO is first-word-fall-through: out_* reflect the head entry while out_valid=1. Simultaneous push and pop in one cycle leaves fifo_count unchanged. Pop on empty or push on full are impossible by construction; assertions cover both.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is 0..FIFO_DEPTH.
- Minimum accept-to-out_valid latency = core latency + 3 cycles.
- Reset mid-operation: in-flight request and all FIFO contents are discarded. Core start is deasserted immediately (async).
- Half results: out_result = {16'h0000, core_result[15:0]}.

Decomposition:
- Package fp_alu_pkg:
  - op-code constants (OP_ADD..OP_DIV)
  - flag bit index FLAG_INVALID=4
  - FSM state encoding
  - response entry field widths
- Sub-module fp_resp_fifo (parametrised width/depth, FWFT, count output) holds the response queue.
- The two fp_alu_core instances are reused unchanged.

Test Plan:
- Single ADD: a=0x3FC00000, b=0x40100000, mode=1, tag=3 -> out_result=0x40700000, out_tag=3, out_mode=1, flags[4]=0, timeout=0.
- Half MUL: a=0x00004000, b=0x00004200, mode=0 -> out_result=0x00004600. The wide core's start is never asserted.
- Backpressure: out_ready=0, issue 5 half ADDs 0x3C00+0x3C00 with tags 0..4 -> in_ready drops after 4 accepts, fifo_count=4. Raise out_ready -> tags pop 0,1,2,3 each 0x00004000, then 5th accepted.
- Illegal op: in_op=3'b111 -> out_result=0, out_flags=5'b10000, no core start pulse, response within 3 cycles.
- Watchdog: stub core never asserts valid_out -> entry after TIMEOUT cycles with out_timeout=1, flags=5'b10000. A later spurious valid_out produces no entry.
- Reset mid-op: assert rst_n=0 during WAIT with 2 entries queued -> out_valid=0, fifo_count=0, busy=0 immediately. Next request completes normally.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the dual-format FP ALU dispatcher: op codes, flag
// layout, dispatcher FSM states and response entry field widths.
package fp_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam int FLAG_INVALID = 4;
    localparam int RESULT_W     = 32;
    localparam int FLAGS_W      = 5;

    // Flags reported for requests that never reached a core or were abandoned.
    localparam logic [FLAGS_W-1:0] FLAGS_FORCED = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PUSH
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/fp_alu_core.sv
// Parameterised FP add/sub/mul/div unit: truncating, denormals flushed to zero,
// result and flags appear LAT cycles after a start pulse with a one-cycle valid.
module fp_alu_core
    import fp_alu_pkg::*;
#(
    parameter int E   = 8,
    parameter int F   = 23,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [2:0]   op_i,
    input  logic [E+F:0] a_i,
    input  logic [E+F:0] b_i,
    output logic         valid_o,
    output logic [E+F:0] result_o,
    output logic [4:0]   flags_o
);
    localparam int M    = F + 1;
    localparam int X    = M + 3;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int EMAX = (1 << E) - 1;

    logic           sa, sb, za, zb, special;
    logic [E-1:0]   ea, eb;
    logic [M-1:0]   ma, mb, m_l, m_s;
    logic [X-1:0]   l_x, s_x, sum_x, norm_x;
    logic [2*M-1:0] prod, quo;
    logic           sign_r, zero_r, nan_r, inf_r, s_l, eff_sub;
    logic [F-1:0]   frac_r;
    int             exp_r, e_l, d, p;
    logic [E+F:0]   res_c;
    logic [4:0]     flags_c;
    logic [7:0]     cnt_q;

    assign sa      = a_i[E+F];
    assign sb      = b_i[E+F];
    assign ea      = a_i[E+F-1:F];
    assign eb      = b_i[E+F-1:F];
    assign za      = (ea == '0);
    assign zb      = (eb == '0);
    assign ma      = za ? '0 : {1'b1, a_i[F-1:0]};
    assign mb      = zb ? '0 : {1'b1, b_i[F-1:0]};
    assign special = (&ea) | (&eb);

    always_comb begin
        sign_r = 1'b0; zero_r = 1'b0; nan_r = special; inf_r = 1'b0;
        exp_r = 0; frac_r = '0; flags_c = '0; res_c = '0;
        s_l = sa; e_l = 0; d = 0; p = 0; eff_sub = 1'b0;
        m_l = '0; m_s = '0; l_x = '0; s_x = '0; sum_x = '0; norm_x = '0;
        prod = '0; quo = '0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                eff_sub = sa ^ sb ^ (op_i == OP_SUB);
                if (a_i[E+F-1:0] >= b_i[E+F-1:0]) begin
                    s_l = sa; e_l = int'(ea); d = int'(ea) - int'(eb); m_l = ma; m_s = mb;
                end else begin
                    s_l = sb ^ (op_i == OP_SUB); e_l = int'(eb); d = int'(eb) - int'(ea);
                    m_l = mb; m_s = ma;
                end
                l_x   = {1'b0, m_l, 2'b00};
                s_x   = {1'b0, m_s, 2'b00} >> d;
                sum_x = eff_sub ? (l_x - s_x) : (l_x + s_x);
                for (int i = 0; i < X; i++) begin
                    if (sum_x[i]) p = i;
                end
                // Renormalise so the hidden bit sits at M+1.
                norm_x = (p == X - 1) ? (sum_x >> 1) : (sum_x << (M + 1 - p));
                frac_r = norm_x[M:2];
                exp_r  = e_l + p - (M + 1);
                sign_r = s_l;
                zero_r = (sum_x == '0);
            end
            OP_MUL: begin
                prod   = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
                sign_r = sa ^ sb;
                zero_r = za | zb;
                if (prod[2*M-1]) begin
                    frac_r = prod[2*M-2 -: F];
                    exp_r  = int'(ea) + int'(eb) - BIAS + 1;
                end else begin
                    frac_r = prod[2*M-3 -: F];
                    exp_r  = int'(ea) + int'(eb) - BIAS;
                end
            end
            OP_DIV: begin
                quo    = {ma, {M{1'b0}}} / {{M{1'b0}}, (zb ? M'(1) : mb)};
                sign_r = sa ^ sb;
                zero_r = za;
                if (quo[M]) begin
                    frac_r = quo[M-1:1];
                    exp_r  = int'(ea) - int'(eb) + BIAS;
                end else begin
                    frac_r = quo[M-2:0];
                    exp_r  = int'(ea) - int'(eb) + BIAS - 1;
                end
                if (zb && za) begin
                    nan_r = 1'b1;
                end else if (zb) begin
                    inf_r      = 1'b1;
                    flags_c[3] = 1'b1;
                end
            end
            default: nan_r = 1'b1;
        endcase

        if (nan_r) begin
            res_c = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
            flags_c[FLAG_INVALID] = 1'b1;
        end else if (inf_r) begin
            res_c = {sign_r, {E{1'b1}}, {F{1'b0}}};
        end else if (zero_r) begin
            res_c = '0;
        end else if (exp_r >= EMAX) begin
            res_c = {sign_r, {E{1'b1}}, {F{1'b0}}};
            flags_c[2] = 1'b1;
        end else if (exp_r <= 0) begin
            flags_c[1] = 1'b1;
        end else begin
            res_c = {sign_r, exp_r[E-1:0], frac_r};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            result_o <= '0;
            flags_o  <= '0;
        end else if (start_i) begin
            cnt_q    <= 8'(LAT);
            result_o <= res_c;
            flags_o  <= flags_c;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign valid_o = (cnt_q == 8'd1);

endmodule

// File: rtl/fp_resp_fifo.sv
// First-word-fall-through response queue with occupancy count; the head entry
// is presented combinationally and reads as zero while the queue is empty.
module fp_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PTR_W'(1);
            if (pop_i)  rd_q <= rd_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = count_q;

    assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && (count_q == '0)));
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push_i && !pop_i && (count_q == (PTR_W+1)'(DEPTH))));

endmodule

// File: rtl/fp_alu_dispatch.sv
// Valid/ready front end serialising tagged requests onto a wide or narrow FP
// core, with a watchdog and a FWFT response queue.
module fp_alu_dispatch
    import fp_alu_pkg::*;
#(
    parameter int E_HI       = 8,
    parameter int F_HI       = 23,
    parameter int E_LO       = 5,
    parameter int F_LO       = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64,
    parameter int CORE_LAT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_op,
    input  logic                          in_mode,
    input  logic [31:0]                   in_a,
    input  logic [31:0]                   in_b,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_result,
    output logic [4:0]                    out_flags,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          out_mode,
    output logic                          out_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int W_HI    = E_HI + F_HI + 1;
    localparam int W_LO    = E_LO + F_LO + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int WD_W    = $clog2(TIMEOUT) + 1;
    localparam int ENTRY_W = RESULT_W + FLAGS_W + TAG_W + 2;

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic                 mode_q, mode_d, tmo_q, tmo_d, ready_en_q;
    logic [31:0]          a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [RESULT_W-1:0]  res_q, res_d, sel_result;
    logic [FLAGS_W-1:0]   flags_q, flags_d, sel_flags, flags_hi, flags_lo;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 start_hi, start_lo, valid_hi, valid_lo, sel_valid, push, pop;
    logic [W_HI-1:0]      result_hi;
    logic [W_LO-1:0]      result_lo;
    logic [ENTRY_W-1:0]   entry_in, entry_out;

    assign sel_valid  = mode_q ? valid_hi : valid_lo;
    assign sel_result = mode_q ? result_hi : {{(RESULT_W-W_LO){1'b0}}, result_lo};
    assign sel_flags  = mode_q ? flags_hi : flags_lo;

    always_comb begin
        state_d = state_q; op_d = op_q; mode_d = mode_q; a_d = a_q; b_d = b_q;
        tag_d = tag_q; res_d = res_q; flags_d = flags_q; tmo_d = tmo_q; wd_d = wd_q;
        in_ready = 1'b0; start_hi = 1'b0; start_lo = 1'b0; push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ready_en_q && (fifo_count < CNT_W'(FIFO_DEPTH));
                if (in_valid && in_ready) begin
                    op_d = in_op; mode_d = in_mode; a_d = in_a; b_d = in_b; tag_d = in_tag;
                    res_d = '0; flags_d = '0; tmo_d = 1'b0;
                    if (op_legal(in_op)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        flags_d = FLAGS_FORCED;
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_ISSUE: begin
                start_hi = mode_q;
                start_lo = !mode_q;
                wd_d     = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_valid) begin
                    res_d   = sel_result;
                    flags_d = sel_flags;
                    state_d = ST_PUSH;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    flags_d = FLAGS_FORCED;
                    tmo_d   = 1'b1;
                    state_d = ST_PUSH;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_PUSH: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ready_en_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE; op_q <= '0; mode_q <= 1'b0; a_q <= '0; b_q <= '0;
            tag_q <= '0; res_q <= '0; flags_q <= '0; tmo_q <= 1'b0; wd_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q <= state_d; op_q <= op_d; mode_q <= mode_d; a_q <= a_d; b_q <= b_d;
            tag_q <= tag_d; res_q <= res_d; flags_q <= flags_d; tmo_q <= tmo_d; wd_q <= wd_d;
            ready_en_q <= 1'b1;
        end
    end

    fp_alu_core #(.E(E_HI), .F(F_HI), .LAT(CORE_LAT)) u_core_hi (
        .clk(clk), .rst_n(rst_n), .start_i(start_hi), .op_i(op_q),
        .a_i(a_q[W_HI-1:0]), .b_i(b_q[W_HI-1:0]),
        .valid_o(valid_hi), .result_o(result_hi), .flags_o(flags_hi)
    );

    fp_alu_core #(.E(E_LO), .F(F_LO), .LAT(CORE_LAT)) u_core_lo (
        .clk(clk), .rst_n(rst_n), .start_i(start_lo), .op_i(op_q),
        .a_i(a_q[W_LO-1:0]), .b_i(b_q[W_LO-1:0]),
        .valid_o(valid_lo), .result_o(result_lo), .flags_o(flags_lo)
    );

    assign entry_in = {res_q, flags_q, tag_q, mode_q, tmo_q};
    assign pop      = out_valid && out_ready;

    fp_resp_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(push), .data_i(entry_in), .pop_i(pop),
        .valid_o(out_valid), .data_o(entry_out), .count_o(fifo_count)
    );

    assign {out_result, out_flags, out_tag, out_mode, out_timeout} = entry_out;
    assign busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
